// File: rtl/relay_seq_ctrl_if.sv
// Request handshake between a requester and relay_seq_ctrl.
//   req_valid : a switching request is present (requester -> controller)
//   req_ready : controller can accept a request  (controller -> requester)
//   req_on    : 1 closes channel req_sel, 0 opens all channels
//   req_sel   : target channel 0..3
interface relay_seq_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_on;
    logic [1:0] req_sel;

    modport master (
        output req_valid,
        output req_on,
        output req_sel,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_on,
        input  req_sel,
        output req_ready
    );
endinterface

// File: rtl/relay_seq_ctrl.sv
// Break-before-make relay sequencer for four channels.
// A request either closes one channel or opens all of them. When a different relay is
// already closed, all relays are opened for BREAK_CYC cycles first. A newly closed relay
// is then held for SETTLE_CYC cycles before the sequence completes with a done pulse.
// The inhibit interlock opens everything on the next cycle and pulses abort if work was
// cut short or a relay was closed.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   req         : request handshake (slave side)
//   inhibit     : interlock, forces all relays open
//   relay_en    : relay drive, one-hot or all-zero
//   active_on   : a channel is closed and settled
//   active_sel  : index of the closed channel (valid with active_on)
//   busy        : break or settle sequence in progress
//   done, abort : one-cycle completion / termination pulses
module relay_seq_ctrl #(
    parameter int unsigned BREAK_CYC  = 4,
    parameter int unsigned SETTLE_CYC = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    relay_seq_ctrl_if.slave     req,
    input  logic                inhibit,
    output logic [3:0]          relay_en,
    output logic                active_on,
    output logic [1:0]          active_sel,
    output logic                busy,
    output logic                done,
    output logic                abort
);

    // Dwell counter counts down to zero, so the load value is one less than the dwell.
    localparam logic [7:0] BreakLoad  = 8'(BREAK_CYC - 1);
    localparam logic [7:0] SettleLoad = 8'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBreak,
        StSettle
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] relay_q, relay_d;
    logic       act_on_q, act_on_d;
    logic [1:0] act_sel_q, act_sel_d;
    logic       cap_on_q, cap_on_d;
    logic [1:0] cap_sel_q, cap_sel_d;
    logic       done_q, done_d;
    logic       abort_q, abort_d;
    logic       accept;

    assign req.req_ready = (state_q == StIdle) && !inhibit;
    assign accept        = req.req_valid && req.req_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        relay_d   = relay_q;
        act_on_d  = act_on_q;
        act_sel_d = act_sel_q;
        cap_on_d  = cap_on_q;
        cap_sel_d = cap_sel_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;

        if (inhibit) begin
            relay_d  = 4'b0000;
            act_on_d = 1'b0;
            state_d  = StIdle;
            cnt_d    = 8'd0;
            // Everything is cleared next cycle, so a held inhibit aborts only once.
            abort_d  = (state_q != StIdle) || (relay_q != 4'b0000);
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        cap_on_d  = req.req_on;
                        cap_sel_d = req.req_sel;
                        if (req.req_on && act_on_q && (req.req_sel == act_sel_q)) begin
                            done_d = 1'b1;
                        end else if (!req.req_on && (relay_q == 4'b0000)) begin
                            done_d = 1'b1;
                        end else if (relay_q != 4'b0000) begin
                            relay_d  = 4'b0000;
                            act_on_d = 1'b0;
                            state_d  = StBreak;
                            cnt_d    = BreakLoad;
                        end else begin
                            relay_d = 4'b0001 << req.req_sel;
                            state_d = StSettle;
                            cnt_d   = SettleLoad;
                        end
                    end
                end
                StBreak: begin
                    if (cnt_q == 8'd0) begin
                        if (cap_on_q) begin
                            relay_d = 4'b0001 << cap_sel_q;
                            state_d = StSettle;
                            cnt_d   = SettleLoad;
                        end else begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                StSettle: begin
                    if (cnt_q == 8'd0) begin
                        state_d   = StIdle;
                        done_d    = 1'b1;
                        act_on_d  = 1'b1;
                        act_sel_d = cap_sel_q;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    relay_d = 4'b0000;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            relay_q   <= 4'b0000;
            act_on_q  <= 1'b0;
            act_sel_q <= 2'd0;
            cap_on_q  <= 1'b0;
            cap_sel_q <= 2'd0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            relay_q   <= relay_d;
            act_on_q  <= act_on_d;
            act_sel_q <= act_sel_d;
            cap_on_q  <= cap_on_d;
            cap_sel_q <= cap_sel_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
        end
    end

    assign relay_en   = relay_q;
    assign active_on  = act_on_q;
    assign active_sel = act_sel_q;
    assign busy       = (state_q != StIdle);
    assign done       = done_q;
    assign abort      = abort_q;

endmodule
